dpwm_multi: RTL and testbench

DPWM_MULTI -- requirements
Module: dpwm_multi

---
 rtl/dpwm_pkg.sv | 15 +
 rtl/dpwm_chan.sv | 50 +++++
 rtl/dpwm_multi.sv | 138 +++++++++++++
 tb/tb_dpwm_multi.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_pkg.sv
// rtl/dpwm_pkg.sv - shared defaults, dead-time floor and enable FSM encoding for dpwm_multi
package dpwm_pkg;
  localparam int N_CH_DEF       = 2;
  localparam int CW_DEF         = 12;
  localparam int DTW_DEF        = 5;
  localparam int PERIOD_RST_DEF = 999;
  localparam int DT_MIN         = 1;
  localparam int PERIOD_MIN     = 3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } en_state_e;
endpackage

// File: rtl/dpwm_chan.sv
// rtl/dpwm_chan.sv - one complementary output pair: phase-shifted local count, region decode, output flops
module dpwm_chan
  import dpwm_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int DTW = DTW_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [CW-1:0]  i_cnt,
  input  logic [CW-1:0]  i_period,
  input  logic [CW-1:0]  i_ton,
  input  logic [CW-1:0]  i_phase,
  input  logic [DTW-1:0] i_dt1,
  input  logic [DTW-1:0] i_dt2,
  input  logic           i_out_en,
  output logic           o_c1,
  output logic           o_c2
);
  localparam int XW = CW + 2;

  logic [CW-1:0] phase_eff;
  logic [XW-1:0] sum, lcnt, edge_on, edge_off, edge_c2;
  logic          c1_d, c1_q, c2_d, c2_q;

  // Edges are ordered edge_on <= edge_off <= edge_c2, so c1 and c2 decode to disjoint ranges.
  always_comb begin
    phase_eff = (i_phase > i_period) ? '0 : i_phase;
    sum       = XW'(i_cnt) + XW'(phase_eff);
    lcnt      = (sum > XW'(i_period)) ? (sum - XW'(i_period) - XW'(1)) : sum;
    edge_on   = XW'(i_dt1);
    edge_off  = edge_on + XW'(i_ton);
    edge_c2   = edge_off + XW'(i_dt2);
    c1_d      = i_out_en && (lcnt >= edge_on) && (lcnt < edge_off);
    c2_d      = i_out_en && (lcnt >= edge_c2);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      c1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

  assign o_c1 = c1_q;
  assign o_c2 = c2_q;
endmodule

// File: rtl/dpwm_multi.sv
// rtl/dpwm_multi.sv - multi-channel DPWM: master counter, shadow/active config, enable FSM, channel array
module dpwm_multi
  import dpwm_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int CW         = CW_DEF,
  parameter int DTW        = DTW_DEF,
  parameter int PERIOD_RST = PERIOD_RST_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_update,
  input  logic [CW-1:0]      i_period,
  input  logic [N_CH*CW-1:0] i_ton,
  input  logic [N_CH*CW-1:0] i_phase,
  input  logic [DTW-1:0]     i_dt1,
  input  logic [DTW-1:0]     i_dt2,
  output logic [N_CH-1:0]    o_c1,
  output logic [N_CH-1:0]    o_c2,
  output logic               o_sync,
  output logic               o_pending
);
  logic [CW-1:0]      cnt_d, cnt_q;
  logic [CW-1:0]      per_a_d, per_a_q, per_s_d, per_s_q;
  logic [N_CH*CW-1:0] ton_a_d, ton_a_q, ton_s_d, ton_s_q;
  logic [N_CH*CW-1:0] ph_a_d, ph_a_q, ph_s_d, ph_s_q;
  logic [DTW-1:0]     dt1_a_d, dt1_a_q, dt1_s_d, dt1_s_q;
  logic [DTW-1:0]     dt2_a_d, dt2_a_q, dt2_s_d, dt2_s_q;
  logic               pend_d, pend_q, sync_d, sync_q;
  en_state_e          state_d, state_q;

  logic [CW-1:0]  p_eff;
  logic [DTW-1:0] dt1_in, dt2_in;
  logic           wrap, out_en;

  always_comb begin
    p_eff  = (per_a_q < CW'(PERIOD_MIN)) ? CW'(PERIOD_MIN) : per_a_q;
    wrap   = (cnt_q == p_eff);
    dt1_in = (i_dt1 == '0) ? DTW'(DT_MIN) : i_dt1;
    dt2_in = (i_dt2 == '0) ? DTW'(DT_MIN) : i_dt2;
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    sync_d = (cnt_q == '0);

    per_a_d = per_a_q;  ton_a_d = ton_a_q;  ph_a_d = ph_a_q;
    dt1_a_d = dt1_a_q;  dt2_a_d = dt2_a_q;
    per_s_d = per_s_q;  ton_s_d = ton_s_q;  ph_s_d = ph_s_q;
    dt1_s_d = dt1_s_q;  dt2_s_d = dt2_s_q;
    pend_d  = pend_q;

    // An update landing on the wrap edge bypasses the shadow entirely.
    if (wrap) begin
      pend_d = 1'b0;
      if (i_update) begin
        per_a_d = i_period;  ton_a_d = i_ton;  ph_a_d = i_phase;
        dt1_a_d = dt1_in;    dt2_a_d = dt2_in;
      end else if (pend_q) begin
        per_a_d = per_s_q;   ton_a_d = ton_s_q;  ph_a_d = ph_s_q;
        dt1_a_d = dt1_s_q;   dt2_a_d = dt2_s_q;
      end
    end else if (i_update) begin
      per_s_d = i_period;  ton_s_d = i_ton;  ph_s_d = i_phase;
      dt1_s_d = dt1_in;    dt2_s_d = dt2_in;
      pend_d  = 1'b1;
    end

    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = ST_ARMED;
        ST_ARMED: if (wrap) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_OFF;
      endcase
    end

    // Gating on the live enable blanks the very first cycle after it drops.
    out_en = (state_q == ST_RUN) && i_enable;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      per_a_q <= CW'(PERIOD_RST);
      ton_a_q <= '0;
      ph_a_q  <= '0;
      dt1_a_q <= DTW'(DT_MIN);
      dt2_a_q <= DTW'(DT_MIN);
      per_s_q <= CW'(PERIOD_RST);
      ton_s_q <= '0;
      ph_s_q  <= '0;
      dt1_s_q <= DTW'(DT_MIN);
      dt2_s_q <= DTW'(DT_MIN);
      pend_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_OFF;
    end else begin
      cnt_q   <= cnt_d;
      per_a_q <= per_a_d;
      ton_a_q <= ton_a_d;
      ph_a_q  <= ph_a_d;
      dt1_a_q <= dt1_a_d;
      dt2_a_q <= dt2_a_d;
      per_s_q <= per_s_d;
      ton_s_q <= ton_s_d;
      ph_s_q  <= ph_s_d;
      dt1_s_q <= dt1_s_d;
      dt2_s_q <= dt2_s_d;
      pend_q  <= pend_d;
      sync_q  <= sync_d;
      state_q <= state_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    dpwm_chan #(
      .CW  (CW),
      .DTW (DTW)
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_cnt     (cnt_q),
      .i_period  (p_eff),
      .i_ton     (ton_a_q[k*CW +: CW]),
      .i_phase   (ph_a_q[k*CW +: CW]),
      .i_dt1     (dt1_a_q),
      .i_dt2     (dt2_a_q),
      .i_out_en  (out_en),
      .o_c1      (o_c1[k]),
      .o_c2      (o_c2[k])
    );
  end

  assign o_sync    = sync_q;
  assign o_pending = pend_q;
endmodule

// File: tb/tb_dpwm_multi.sv
// tb/tb_dpwm_multi.sv - directed self-checking bench for dpwm_multi
`timescale 1ns/1ps
module tb_dpwm_multi;
  localparam int N_CH = 2;
  localparam int CW   = 12;
  localparam int DTW  = 5;

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_enable = 1'b0;
  logic               i_update = 1'b0;
  logic [CW-1:0]      i_period = '0;
  logic [N_CH*CW-1:0] i_ton = '0;
  logic [N_CH*CW-1:0] i_phase = '0;
  logic [DTW-1:0]     i_dt1 = '0;
  logic [DTW-1:0]     i_dt2 = '0;
  logic [N_CH-1:0]    o_c1, o_c2;
  logic               o_sync, o_pending;

  int n_vec = 0;
  int n_bad = 0;
  int cnt_m, prev_m, per_m;
  int m_ton0, m_ton1, m_d1, m_d2, m_ph1;

  dpwm_multi #(.N_CH(N_CH), .CW(CW), .DTW(DTW), .PERIOD_RST(999)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .i_update  (i_update),
    .i_period  (i_period),
    .i_ton     (i_ton),
    .i_phase   (i_phase),
    .i_dt1     (i_dt1),
    .i_dt2     (i_dt2),
    .o_c1      (o_c1),
    .o_c2      (o_c2),
    .o_sync    (o_sync),
    .o_pending (o_pending)
  );

  always #2.5 i_clk = ~i_clk;

  // {c1, c2} for local count l under the currently active model config
  function automatic logic [1:0] ref_pair(int l, int ton);
    return {(l >= m_d1) && (l < m_d1 + ton), (l >= m_d1 + ton + m_d2)};
  endfunction

  // {c1[1], c1[0], c2[1], c2[0], sync} expected for the counter value prev_m
  function automatic logic [4:0] exp_outs(bit en);
    int ph, l1;
    logic [1:0] p0, p1;
    ph = (m_ph1 > per_m) ? 0 : m_ph1;
    l1 = prev_m + ph;
    if (l1 > per_m) l1 = l1 - per_m - 1;
    p0 = ref_pair(prev_m, m_ton0);
    p1 = ref_pair(l1, m_ton1);
    if (!en) begin
      p0 = 2'b00;
      p1 = 2'b00;
    end
    return {p1[1], p0[1], p1[0], p0[0], (prev_m == 0)};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    prev_m = cnt_m;
    cnt_m  = (cnt_m >= per_m) ? 0 : cnt_m + 1;
    @(negedge i_clk);
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (cnt_m != target && guard < 3000) begin
      tick();
      guard++;
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_update  = 1'b0;
    repeat (3) @(negedge i_clk);
    cnt_m = 0; prev_m = 0; per_m = 999;
    m_ton0 = 0; m_ton1 = 0; m_d1 = 1; m_d2 = 1; m_ph1 = 0;
    i_reset_n = 1'b1;
  endtask

  task automatic set_cfg(int per, int ton0, int ton1, int ph1, int d1, int d2);
    i_period = CW'(per);
    i_ton    = {CW'(ton1), CW'(ton0)};
    i_phase  = {CW'(ph1), CW'(0)};
    i_dt1    = DTW'(d1);
    i_dt2    = DTW'(d2);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    n_vec++; if (o_c1 !== 2'b00) begin n_bad++; $display("FAIL reset_c1 got %b want 00", o_c1); end
    n_vec++; if (o_c2 !== 2'b00) begin n_bad++; $display("FAIL reset_c2 got %b want 00", o_c2); end
    n_vec++; if (o_sync !== 1'b0) begin n_bad++; $display("FAIL reset_sync got %b want 0", o_sync); end
    n_vec++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", o_pending); end
    do_reset();
  endtask

  task automatic test_config();
    logic [4:0] e;
    set_cfg(999, 400, 400, 500, 4, 6);
    i_update = 1'b1; i_enable = 1'b1;
    tick();
    i_update = 1'b0;
    n_vec++; if (o_pending !== 1'b1) begin n_bad++; $display("FAIL cfg_pend_set got %b want 1", o_pending); end
    run_to(999);
    n_vec++; if (o_pending !== 1'b1) begin n_bad++; $display("FAIL cfg_pend_hold got %b want 1", o_pending); end
    tick();
    m_ton0 = 400; m_ton1 = 400; m_ph1 = 500; m_d1 = 4; m_d2 = 6;
    n_vec++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL cfg_pend_clr got %b want 0", o_pending); end
    repeat (1000) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL cfg_wave cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_period_update();
    logic [4:0] e;
    run_to(200);
    i_period = CW'(499); i_update = 1'b1;
    tick();
    i_update = 1'b0;
    n_vec++; if (o_pending !== 1'b1) begin n_bad++; $display("FAIL pu_pend_set got %b want 1", o_pending); end
    run_to(999);
    n_vec++; if (o_pending !== 1'b1) begin n_bad++; $display("FAIL pu_pend_wrap got %b want 1", o_pending); end
    tick();
    per_m = 499;
    n_vec++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL pu_pend_clr got %b want 0", o_pending); end
    repeat (500) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL pu_wave cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_update_at_wrap();
    logic [4:0] e;
    run_to(499);
    set_cfg(999, 200, 200, 500, 4, 6);
    i_update = 1'b1;
    tick();
    i_update = 1'b0;
    per_m = 999; m_ton0 = 200; m_ton1 = 200;
    n_vec++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL uw_pend got %b want 0", o_pending); end
    repeat (1000) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync, o_pending} !== {e, 1'b0}) begin
        n_bad++; $display("FAIL uw_wave cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync, o_pending}, {e, 1'b0});
      end
    end
  endtask

  task automatic test_min_deadtime();
    logic [4:0] e;
    set_cfg(999, 998, 998, 500, 0, 0);
    i_update = 1'b1;
    tick();
    i_update = 1'b0;
    run_to(999);
    tick();
    m_ton0 = 998; m_ton1 = 998; m_d1 = 1; m_d2 = 1;
    repeat (1000) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e || o_c2 !== 2'b00) begin
        n_bad++; $display("FAIL dt_wave cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_enable();
    logic [4:0] e;
    i_enable = 1'b0;
    do_reset();
    set_cfg(999, 400, 400, 500, 4, 6);
    i_update = 1'b1;
    tick();
    i_update = 1'b0;
    run_to(999);
    tick();
    m_ton0 = 400; m_ton1 = 400; m_ph1 = 500; m_d1 = 4; m_d2 = 6;
    run_to(300);
    i_enable = 1'b1;
    repeat (700) begin
      tick();
      e = exp_outs(1'b0);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL en_armed cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
    repeat (200) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL en_run cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
    n_vec++; if (o_c1[0] !== 1'b1) begin n_bad++; $display("FAIL en_mid_c1 got %b want 1", o_c1[0]); end
    i_enable = 1'b0;
    tick();
    n_vec++; if ({o_c1, o_c2} !== 4'b0000) begin n_bad++; $display("FAIL en_drop got %b want 0000", {o_c1, o_c2}); end
    repeat (5) begin
      tick();
      e = exp_outs(1'b0);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL en_off cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] e;
    i_enable = 1'b1;
    run_to(999);
    tick();
    run_to(100);
    n_vec++; if (o_c1[0] !== 1'b1) begin n_bad++; $display("FAIL rm_pre_c1 got %b want 1", o_c1[0]); end
    set_cfg(999, 50, 50, 0, 4, 6);
    i_update = 1'b1;
    tick();
    i_update = 1'b0;
    n_vec++; if (o_pending !== 1'b1) begin n_bad++; $display("FAIL rm_pend_set got %b want 1", o_pending); end
    i_reset_n = 1'b0;
    #1;
    n_vec++;
    if ({o_c1, o_c2, o_sync, o_pending} !== 6'b000000) begin
      n_bad++; $display("FAIL rm_async got %b want 000000", {o_c1, o_c2, o_sync, o_pending});
    end
    do_reset();
    repeat (1000) begin
      tick();
      e = exp_outs(1'b0);
      n_vec++;
      if ({o_c1, o_c2, o_sync, o_pending} !== {e, 1'b0}) begin
        n_bad++; $display("FAIL rm_armed cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync, o_pending}, {e, 1'b0});
      end
    end
    repeat (50) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL rm_run cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_period_clamp();
    logic [4:0] e;
    set_cfg(1, 0, 0, 0, 0, 0);
    i_update = 1'b1;
    tick();
    i_update = 1'b0;
    run_to(999);
    tick();
    per_m = 3; m_ton0 = 0; m_ton1 = 0; m_ph1 = 0; m_d1 = 1; m_d2 = 1;
    repeat (12) begin
      tick();
      e = exp_outs(1'b1);
      n_vec++;
      if ({o_c1, o_c2, o_sync} !== e) begin
        n_bad++; $display("FAIL clamp cnt=%0d got %b want %b", prev_m, {o_c1, o_c2, o_sync}, e);
      end
    end
  endtask

  task automatic test_random_overlap();
    for (int it = 0; it < 12; it++) begin
      i_period = CW'($urandom_range(60, 0));
      i_ton    = {CW'($urandom_range(70, 0)), CW'($urandom_range(70, 0))};
      i_phase  = {CW'($urandom_range(70, 0)), CW'($urandom_range(70, 0))};
      i_dt1    = DTW'($urandom_range(31, 0));
      i_dt2    = DTW'($urandom_range(31, 0));
      i_enable = ($urandom_range(3, 0) != 0);
      i_update = 1'b1;
      repeat (150) begin
        @(negedge i_clk);
        i_update = 1'b0;
        n_vec++;
        if ((o_c1 & o_c2) !== 2'b00) begin
          n_bad++; $display("FAIL overlap it=%0d got c1=%b c2=%b want disjoint", it, o_c1, o_c2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_period_update();
    test_update_at_wrap();
    test_min_deadtime();
    test_enable();
    test_reset_midrun();
    test_period_clamp();
    test_random_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
